// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default constants shared by the
// UART receive path. The PARITY state exists only when UART_RX_PARITY_EN
// is defined.
package uart_pkg;

  localparam int CLK_DIV_9600_10MHZ = 1042;
  localparam int DATA_WIDTH_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO for received words. A push into a full
// FIFO is accepted only when a pop happens in the same cycle. The head is
// forced to zero while empty so nothing stale is shown after reset.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1 style, LSB first) feeding a small FIFO.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_9600_10MHZ,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        uart_rx_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overrun_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  uart_state_e           state, state_n;
  logic [1:0]            sync;
  logic                  rx_prev, rx_s, fall, tick;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ld_half, ld_full, shift_en, par_smp;
  logic                  stop_good, stop_bad, par_bad, push_q;
  logic                  full, empty, pop;

  assign rx_s = sync[1];
  assign fall = rx_prev & ~rx_s;
  assign tick = (cnt == '0);

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) {rx_prev, sync} <= '1;
    else       {rx_prev, sync} <= {sync, uart_rx_i};
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; every sample point is a counter tick.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (fall) state_n = ST_START;
      ST_START: if (tick) state_n = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
        state_n = ST_PARITY;
`else
        state_n = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (tick) state_n = ST_STOP;
`endif
      ST_STOP:      if (tick) state_n = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_IDLE:  ld_half = fall;
      ST_START: ld_full = tick;
      ST_DATA: begin
        ld_full  = tick;
        shift_en = tick;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        ld_full = tick;
        par_smp = tick;
      end
`endif
      ST_STOP: begin
        stop_good = tick & rx_s;
        stop_bad  = tick & ~rx_s;
      end
      default: ;
    endcase
  end

  // Bit timer, bit index, shift register, push request and framing flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (ld_half)       cnt <= CNT_HALF;
      else if (ld_full)  cnt <= CNT_FULL;
      else if (!tick)    cnt <= cnt - 1'b1;
      if (ld_half)       idx <= '0;
      else if (shift_en) idx <= idx + 1'b1;
      if (shift_en)      shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      push_q      <= stop_good & ~par_bad;
      frame_err_o <= stop_bad;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  // Parity check: XOR of data and parity bit must equal the selected sense.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (ld_half)      par_bad <= 1'b0;
      else if (par_smp) par_bad <= ((^shreg) ^ rx_s) != PAR_SENSE;
      parity_err_o <= par_smp & (((^shreg) ^ rx_s) != PAR_SENSE);
    end
  end
`else
  logic unused_par_odd;
  assign unused_par_odd = (PARITY_ODD != 0);
  assign par_bad        = 1'b0;
  assign parity_err_o   = 1'b0;
`endif

  assign valid_o   = ~empty;
  assign pop       = valid_o & ready_i;
  assign overrun_o = push_q & full & ~pop;

  uart_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_q),
    .data_i  (shreg),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven frames plus hand-written corner sequences.
// Received words are checked against a scoreboard queue as they are popped.
// Uses a shortened bit period so the run stays short.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 64;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int PODD    = 0;

  logic                   clk = 1'b0;
  logic                   rst_i, uart_rx_i, ready_i;
  logic [DW-1:0]          data_o;
  logic                   valid_o, frame_err_o, parity_err_o, overrun_o;
  logic [$clog2(DEPTH):0] level_o;

  uart_rx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (PODD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .uart_rx_i    (uart_rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, val_cnt = 0;
  logic [DW-1:0] exp_q [$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    int         exp_fe;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Sample outputs at a negedge (inputs already settled for the next edge),
  // then advance one cycle.
  task automatic tick();
    if (valid_o)      val_cnt++;
    if (frame_err_o)  fe_cnt++;
    if (parity_err_o) pe_cnt++;
    if (overrun_o)    ov_cnt++;
    if (valid_o && ready_i && !rst_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: popped 0x%0h with nothing expected", data_o);
      end else begin
        chk("sb_data", int'(data_o), int'(exp_q.pop_front()));
      end
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    uart_rx_i = b;
    ticks(CLK_DIV);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ (PODD != 0) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  initial begin
    int fe0, ov0, v0, pe0, c;

    rst_i = 1'b1; uart_rx_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    ticks(3);
    chk("rst_valid", valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_flags", {frame_err_o, parity_err_o, overrun_o}, 0);
    rst_i = 1'b0;
    ticks(4);

    // Table: good frames and one frame with a low stop bit.
    vecs[0] = '{8'h40, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 0};
    for (int k = 0; k < 6; k++) begin
      fe0 = fe_cnt;
      if (vecs[k].exp_push) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop);
      uart_rx_i = 1'b1;
      ticks(2 * CLK_DIV);
      chk("vec_frame_err", fe_cnt - fe0, vecs[k].exp_fe);
      chk("vec_drained", exp_q.size(), 0);
    end

    // Latency: valid_o must appear within CLK_DIV+2 of the stop mid-point.
    exp_q.push_back(8'h40);
    v0 = val_cnt;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(i == 6);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b1 ^ (PODD != 0));
`endif
    uart_rx_i = 1'b1;
    c = 0;
    while (c < 3 * CLK_DIV && val_cnt == v0) begin
      tick();
      c++;
    end
    chk("lat_in_bound", int'(c <= CLK_DIV / 2 + CLK_DIV + 2), 1);
    ticks(2 * CLK_DIV);
    chk("lat_drained", exp_q.size(), 0);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    ready_i = 1'b0;
    ov0 = ov_cnt;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1);
    end
    uart_rx_i = 1'b1;
    ticks(2 * CLK_DIV);
    chk("ovr_level", level_o, 4);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_head", data_o, 8'h01);
    ready_i = 1'b1;
    ticks(10);
    chk("ovr_drained", exp_q.size(), 0);
    chk("ovr_level_end", level_o, 0);

    // Break: low stop bit, line held low three more bit times.
    ready_i = 1'b0;
    fe0 = fe_cnt; v0 = val_cnt;
    send_frame(8'hA5, 1'b0);
    ticks(3 * CLK_DIV);
    uart_rx_i = 1'b1;
    ticks(2 * CLK_DIV);
    chk("brk_frame_err", fe_cnt - fe0, 1);
    chk("brk_level", level_o, 0);
    chk("brk_valid", val_cnt - v0, 0);
    ready_i = 1'b1;

    // Glitch shorter than half a bit is ignored.
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = val_cnt; pe0 = pe_cnt;
    uart_rx_i = 1'b0;
    ticks(CLK_DIV / 4);
    uart_rx_i = 1'b1;
    ticks(2 * CLK_DIV);
    chk("glt_valid", val_cnt - v0, 0);
    chk("glt_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    ticks(2 * CLK_DIV);
    chk("glt_next_frame", exp_q.size(), 0);

    // Reset in the middle of a 0xFF frame, then a clean 0x12.
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send_bit(1'b0);
    uart_rx_i = 1'b1;
    ticks(3 * CLK_DIV);
    rst_i = 1'b1;
    ticks(2);
    rst_i = 1'b0;
    ticks(8 * CLK_DIV);
    chk("rmid_level", level_o, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    ticks(2 * CLK_DIV);
    chk("rmid_received", exp_q.size(), 0);
    chk("rmid_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit is flagged and dropped; correct one is received.
    pe0 = pe_cnt; v0 = val_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    ticks(2 * CLK_DIV);
    chk("par_err_pulse", pe_cnt - pe0, 1);
    chk("par_err_nopush", val_cnt - v0, 0);
    par_flip = 1'b0;
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    ticks(2 * CLK_DIV);
    chk("par_ok_nopulse", pe_cnt - pe0, 0);
    chk("par_ok_received", exp_q.size(), 0);
`else
    chk("no_parity_err", pe_cnt, 0);
`endif

    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1042: clock cycles per UART bit, minimum 8 (1042 gives 9600 baud at 10 MHz).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, range 5..9.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries, a power of two, at least 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; it is only used when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port uart_rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port data_o, output, DATA_WIDTH bits: the word at the FIFO head.
REQ-009 SHALL have port valid_o, output, 1 bit: FIFO not empty.
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accept.
REQ-011 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 SHALL have port parity_err_o, output, 1 bit: one-cycle pulse on parity mismatch.
REQ-013 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a good frame is dropped because the FIFO is full.
REQ-014 SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-015 SHALL pass uart_rx_i through a 2-flop synchroniser; all further references are to the synchronised signal.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE, using a bit-period counter and a bit index.
REQ-017 IDLE SHALL move to START on a 1-to-0 transition of the line and load the counter with CLK_DIV/2.
REQ-018 START SHALL resample the line at mid-bit: low moves to DATA; high is a glitch and returns to IDLE with no flag.
REQ-019 DATA SHALL sample DATA_WIDTH bits LSB-first, each CLK_DIV cycles after the previous sample, then move to PARITY if enabled, otherwise to STOP.
REQ-020 STOP SHALL sample one bit: high means the frame is good; low pulses frame_err_o, discards the word and moves to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until the line is high, so a break condition yields exactly one frame_err_o pulse.
REQ-022 A good frame SHALL be written to the FIFO on the cycle after the stop-bit sample, and valid_o SHALL rise on the following cycle.
REQ-023 Good frame with FIFO full: the word SHALL be dropped, overrun_o pulsed, and the FIFO contents left unchanged.
REQ-024 A pop SHALL occur when valid_o and ready_i are both high; data_o SHALL show the next entry on the following cycle.
REQ-025 A push and a pop in the same cycle SHALL leave level_o unchanged, and a full FIFO SHALL accept that push with no overrun.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full SHALL be detected as level_o == FIFO_DEPTH.
REQ-027 data_o SHALL be don't-care while valid_o is low.

Reset
REQ-028 rst_i high at a clock edge SHALL return the FSM to IDLE, clear the counters and the FIFO, and set the synchroniser flops to 1.
REQ-029 After reset, outputs SHALL be valid_o=0, level_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0 and data_o=0.
REQ-030 A frame in progress when reset is asserted SHALL be abandoned with no flag and no push.

Configuration
REQ-031 With macro UART_RX_PARITY_EN defined: the PARITY state samples one bit after the data bits, and a mismatch against PARITY_ODD pulses parity_err_o and discards the word.
REQ-032 With the macro undefined: the PARITY state and its logic are absent, and parity_err_o is tied to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum and the default constants CLK_DIV_9600_10MHZ = 1042 and DATA_WIDTH_DEF = 8.
REQ-034 The FIFO SHALL be a sub-module named uart_fifo, parameterised by width and depth, with push/pop/full/empty/level ports.

Verification
REQ-035 Default build: frame 0x40 at 9600 baud with ready_i=1 -> valid_o rises CLK_DIV+2 cycles after the stop-bit mid-point at the latest, with data_o=0x40.
REQ-036 Default build: 5 back-to-back frames 0x01..0x05 with ready_i=0 -> level_o=4 and one overrun_o pulse; then draining with ready_i=1 yields 0x01..0x04.
REQ-037 Default build: frame 0xA5 with stop bit low, then line held low for 3 bit times -> exactly one frame_err_o pulse and level_o stays 0.
REQ-038 Default build: low glitch of CLK_DIV/4 cycles on an idle line -> no valid_o and no flags, and a following frame 0x3C is received correctly.
REQ-039 With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 0 -> parity_err_o pulses and no push; the same frame with parity bit 1 -> 0x07 is received.
REQ-040 Default build: rst_i asserted mid-DATA of frame 0xFF, then frame 0x12 sent -> only 0x12 is received, with no flags.
